// File: rtl/mem_responder.sv
// Memory-side target for the VeriRISC mem_rd/mem_wr strobes, with WAIT_STATES wait cycles before each response.
// Define MEM_RESP_CLEAR_EN to make rst also zero every storage word.
module mem_responder #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic              write_ack,
  output logic              busy,
  output logic              proto_err
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [3:0] LAST_WAIT = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_DONE,
    S_WR_WAIT,
    S_WR_DONE
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_rd_prev;
  logic                r_wr_prev;
  logic                r_entered;
  logic [AWIDTH-1:0]   r_addr_q;
  logic [DWIDTH-1:0]   r_data_q;
  logic [DWIDTH-1:0]   r_data_out;
  logic                r_data_valid;
  logic                r_write_ack;
  logic                r_busy;
  logic                r_proto_err;
  logic [DWIDTH-1:0]   r_mem [DEPTH];

  logic w_rd_edge;
  logic w_wr_edge;
  logic w_commit;

  // Prev registers reset to 0, so a strobe already high out of reset is an edge.
  assign w_rd_edge = mem_rd & ~r_rd_prev;
  assign w_wr_edge = mem_wr & ~r_wr_prev;
  assign w_commit  = (r_state == S_WR_DONE) && !r_entered;

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign write_ack  = r_write_ack;
  assign busy       = r_busy;
  assign proto_err  = r_proto_err;

`ifdef MEM_RESP_CLEAR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      r_mem[r_addr_q] <= r_data_q;
    end
  end
`else
  // No reset on the array so a preloaded image survives rst.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_addr_q] <= r_data_q;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rd_prev    <= 1'b0;
      r_wr_prev    <= 1'b0;
      r_entered    <= 1'b0;
      r_addr_q     <= '0;
      r_data_q     <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_write_ack  <= 1'b0;
      r_busy       <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_rd_prev   <= mem_rd;
      r_wr_prev   <= mem_wr;
      r_write_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_entered <= 1'b0;
          if (w_rd_edge && w_wr_edge) begin
            r_proto_err <= 1'b1;
          end else if (w_rd_edge) begin
            r_addr_q <= addr;
            r_busy   <= 1'b1;
            r_state  <= (WAIT_STATES == 0) ? S_RD_DONE : S_RD_WAIT;
          end else if (w_wr_edge) begin
            r_addr_q <= addr;
            r_data_q <= data_in;
            r_busy   <= 1'b1;
            r_state  <= (WAIT_STATES == 0) ? S_WR_DONE : S_WR_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem_wr) r_proto_err <= 1'b1;
          if (!mem_rd) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == LAST_WAIT) begin
            r_state <= S_RD_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RD_DONE: begin
          if (mem_wr) r_proto_err <= 1'b1;
          if (!r_entered) begin
            r_data_out   <= r_mem[r_addr_q];
            r_data_valid <= 1'b1;
            r_busy       <= 1'b0;
            r_entered    <= 1'b1;
          end else if (!mem_rd) begin
            r_data_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_WR_WAIT: begin
          if (mem_rd) r_proto_err <= 1'b1;
          if (!mem_wr) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == LAST_WAIT) begin
            r_state <= S_WR_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WR_DONE: begin
          if (mem_rd) r_proto_err <= 1'b1;
          // The array write happens in the storage block on this same entry cycle.
          if (!r_entered) begin
            r_write_ack <= 1'b1;
            r_busy      <= 1'b0;
            r_entered   <= 1'b1;
          end else if (!mem_wr) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: two responders (WAIT_STATES=1 and 3) share stimulus; each is checked against its own latency.
module tb_mem_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic       mem_rd, mem_wr;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] dout1, dout3;
  logic       dv1, dv3, ack1, ack3, busy1, busy3, perr1, perr3;
  int         n_cmp = 0;
  int         n_mis = 0;

`ifdef MEM_RESP_CLEAR_EN
  localparam logic [7:0] EXP_AFTER_RST = 8'h00;
`else
  localparam logic [7:0] EXP_AFTER_RST = 8'hA5;
`endif

  always #5 clk = ~clk;

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .data_in(data_in),
    .data_out(dout1), .data_valid(dv1), .write_ack(ack1), .busy(busy1), .proto_err(perr1)
  );

  mem_responder #(.AWIDTH(5), .DWIDTH(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .data_in(data_in),
    .data_out(dout3), .data_valid(dv3), .write_ack(ack3), .busy(busy3), .proto_err(perr3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write held 5 cycles; ack at +2 for WS=1, +4 for WS=3. Addr/data scrambled after capture.
  task automatic wr_both(input logic [4:0] a, input logic [7:0] d);
    addr = a; data_in = d; mem_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        chk("wr_busy1", busy1, 1'b1);
        chk("wr_busy3", busy3, 1'b1);
        addr = ~a; data_in = ~d;
      end
      chk("wr_ack1", ack1, (i == 2));
      chk("wr_ack3", ack3, (i == 4));
    end
    mem_wr = 1'b0;
    tick();
    chk("wr_ack1_end", ack1, 1'b0);
    chk("wr_ack3_end", ack3, 1'b0);
    $display("write addr=%h data=%h", a, d);
  endtask

  // Read held 5 cycles; valid from +2 (WS=1) and +4 (WS=3), cleared one cycle after drop.
  task automatic rd_both(input logic [4:0] a, input logic [7:0] exp);
    addr = a; mem_rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin
        chk("rd_busy1", busy1, 1'b1);
        chk("rd_busy3", busy3, 1'b1);
        addr = ~a;
      end
      chk("rd_dv1", dv1, (i >= 2));
      chk("rd_dv3", dv3, (i >= 4));
    end
    chk("rd_data1", dout1, exp);
    chk("rd_data3", dout3, exp);
    mem_rd = 1'b0;
    tick();
    chk("rd_dv1_end", dv1, 1'b0);
    chk("rd_dv3_end", dv3, 1'b0);
    chk("rd_hold1", dout1, exp);
    $display("read addr=%h data1=%h data3=%h expected=%h", a, dout1, dout3, exp);
  endtask

  initial begin
    rst = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; data_in = '0;
    #3;
    chk("rst_dv", dv1, 1'b0);
    chk("rst_ack", ack3, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_perr", perr3, 1'b0);
    chk("rst_dout", dout1, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic write then read.
    wr_both(5'h03, 8'hA5);
    rd_both(5'h03, 8'hA5);

    // Read aborted after 2 cycles (WS=3 still waiting).
    addr = 5'h03; mem_rd = 1'b1;
    tick();
    chk("ab_rd_busy_a", busy3, 1'b1);
    tick();
    chk("ab_rd_busy_b", busy3, 1'b1);
    mem_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_rd_busy3", busy3, 1'b0);
      chk("ab_rd_dv3", dv3, 1'b0);
    end
    $display("aborted read addr=03");
    rd_both(5'h03, 8'hA5);

    // Write aborted after 1 cycle: no ack, old contents kept.
    wr_both(5'h1F, 8'h5A);
    addr = 5'h1F; data_in = 8'h3C; mem_wr = 1'b1;
    tick();
    mem_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ab_wr_ack1", ack1, 1'b0);
      chk("ab_wr_ack3", ack3, 1'b0);
    end
    $display("aborted write addr=1f data=3c");
    rd_both(5'h1F, 8'h5A);

    // Simultaneous rd and wr edges.
    mem_rd = 1'b1; mem_wr = 1'b1;
    tick();
    chk("perr1", perr1, 1'b1);
    chk("perr3", perr3, 1'b1);
    chk("perr_busy", busy3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("perr_dv", dv1 | dv3, 1'b0);
      chk("perr_ack", ack1 | ack3, 1'b0);
    end
    mem_rd = 1'b0; mem_wr = 1'b0;
    tick();
    tick();
    chk("perr_sticky", perr3, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("perr_cleared", perr1 | perr3, 1'b0);
    #1 rst = 1'b0;
    tick();
    $display("proto error case done");

    // Reset in the middle of a WS=3 wait.
    wr_both(5'h02, 8'h77);
    rd_both(5'h02, 8'h77);
    addr = 5'h03; mem_rd = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_dv", dv1 | dv3, 1'b0);
    chk("mid_rst_busy", busy1 | busy3, 1'b0);
    chk("mid_rst_dout3", dout3, 8'h00);
    chk("mid_rst_dout1", dout1, 8'h00);
    mem_rd = 1'b0;
    #1 rst = 1'b0;
    tick();
    $display("reset mid-access done");
    rd_both(5'h03, EXP_AFTER_RST);

    // Back-to-back accesses with one low cycle between strobes.
    wr_both(5'h00, 8'h11);
    wr_both(5'h01, 8'h22);
    rd_both(5'h00, 8'h11);
    rd_both(5'h01, 8'h22);
    chk("b2b_perr", perr1 | perr3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side target for the VeriRISC control unit's `mem_rd`/`mem_wr` strobes.
- Holds a 2**AWIDTH x DWIDTH synchronous store and inserts a configurable number of wait states.
- Signals read-data-valid and write-complete back to the datapath.
- Sits between the control unit, the address mux and the data bus; replaces the zero-latency memory model.

Parameters:
- AWIDTH, 5: address width; depth = 2**AWIDTH words.
- DWIDTH, 8: data word width.
- WAIT_STATES, 1: cycles between request capture and response, range 0..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- mem_rd  input  1  read strobe, level, held by initiator for the whole access
- mem_wr  input  1  write strobe, level, held by initiator for the whole access
- addr  input  AWIDTH  word address
- data_in  input  DWIDTH  write data
- data_out  output  DWIDTH  read data
- data_valid  output  1  data_out valid for the current read
- write_ack  output  1  one-cycle pulse when a write commits
- busy  output  1  access in progress (request captured, response not yet given)
- proto_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst=1): state=IDLE, wait counter=0, data_out=0, data_valid=0, write_ack=0, busy=0, proto_err=0. Storage contents are untouched unless MEM_RESP_CLEAR_EN is defined.
- Request detection: registered copies of mem_rd/mem_wr; a start is a 0->1 edge seen at a clk edge. A strobe high coming out of reset counts as an edge on the first clock.
- States: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE.
- IDLE, rd edge only: capture addr into addr_q; busy<=1; go to RD_WAIT, or straight to RD_DONE if WAIT_STATES=0.
- IDLE, wr edge only: capture addr_q and data_q; busy<=1; go to WR_WAIT, or WR_DONE if WAIT_STATES=0.
- IDLE, rd and wr edges on the same cycle: proto_err<=1; no access; stay IDLE.
- RD_WAIT: count WAIT_STATES cycles, then go to RD_DONE.
  - mem_rd dropping during the wait aborts: go to IDLE, busy<=0, no data_valid.
- RD_DONE (entry cycle): data_out<=mem[addr_q]; data_valid<=1; busy<=0.
  - Stay while mem_rd=1.
  - mem_rd=0: data_valid<=0, go to IDLE. data_out holds its last value.
- WR_WAIT: count WAIT_STATES cycles, then go to WR_DONE.
  - mem_wr dropping during the wait aborts: no commit, go to IDLE.
- WR_DONE (entry cycle): mem[addr_q]<=data_q; write_ack pulses for exactly 1 cycle; busy<=0.
  - Stay until mem_wr=0, then go to IDLE. No second commit while mem_wr is held.
- Read latency, with the edge sampled at clk edge N:
  - data_valid high after edge N+WAIT_STATES+1.
  - WAIT_STATES=0 gives valid after edge N+1, which matches the control unit's INST_FETCH->INST_LOAD spacing.
- Strobe opposite to the one in progress, asserted in any non-IDLE state: proto_err<=1; the current access continues unaffected.
- Address/data changes after capture are ignored; only addr_q/data_q are used.
- Address wrap: full AWIDTH range is valid; no out-of-range case.
- proto_err clears only on rst.
- Reset mid-access: abort immediately; no partial write; all outputs go to their reset values.

Optional Feature:
- Macro: MEM_RESP_CLEAR_EN.
- Defined: rst also clears every storage word to 0, so a read after reset returns 0.
- Undefined: storage has no reset and keeps its contents across rst. This allows a preloaded program image via $readmemh.

Test Plan:
- WAIT_STATES=1: write 8'hA5 to addr 5'h03 with mem_wr held 4 cycles -> write_ack high exactly 1 cycle, 2 cycles after the edge. Then read 5'h03 -> data_out=8'hA5, data_valid high 2 cycles after the mem_rd edge and staying high until mem_rd drops.
- WAIT_STATES=3: mem_rd high 2 cycles then low -> no data_valid, busy returns to 0, state IDLE. Next read of 5'h03 returns 8'hA5.
- WAIT_STATES=3: mem_wr of 8'h3C to 5'h1F dropped after 1 cycle -> no write_ack. Reading 5'h1F returns the previous contents.
- mem_rd and mem_wr rising on the same edge -> proto_err=1 next cycle, no data_valid, no write_ack. proto_err stays 1 until rst pulse.
- Reset mid-access: rst asserted during RD_WAIT -> data_valid=0, busy=0, data_out=0 immediately (asynchronous). Then:
  - MEM_RESP_CLEAR_EN defined: reading 5'h03 returns 8'h00.
  - Undefined: reading 5'h03 returns 8'hA5.
- Back-to-back: write 8'h11 to 5'h00, write 8'h22 to 5'h01, read 5'h00, read 5'h01, each strobe separated by 1 low cycle -> reads return 8'h11 and 8'h22, with no proto_err.
